// File: rtl/bus_control_pipe.sv
// Registered main-bus control decoder: one capture stage driving one-cold assert/load/address
// lines, with a memory-bridge wait-state handshake, timeout abort and sticky error flags.
module bus_control_pipe #(
  parameter int BUS_SEL_W  = 4,
  parameter int ADDR_SEL_W = 3,
  parameter int MEM_SLOT   = 15,
  parameter int WAIT_MAX   = 7
) (
  input  logic                         Clock_In,
  input  logic                         Reset_In,
  input  logic                         Ctrl_Valid,
  input  logic [BUS_SEL_W-1:0]         Bus_Assert,
  input  logic [BUS_SEL_W-1:0]         Bus_Load,
  input  logic [ADDR_SEL_W-1:0]        AddrSel,
  input  logic                         Mem_Ready,
  input  logic                         Clear_Err,
  output logic                         Stall,
  output logic                         Stage_Valid,
  output logic [(2**BUS_SEL_W)-1:0]    Assert_N,
  output logic [(2**BUS_SEL_W)-1:0]    Load_N,
  output logic [(2**ADDR_SEL_W)-1:0]   AddrSel_N,
  output logic                         Mem_Req,
  output logic                         MemBridge_Direction,
  output logic                         Contention_Err,
  output logic                         Timeout_Err
);

  localparam int NB    = 2**BUS_SEL_W;
  localparam int NA    = 2**ADDR_SEL_W;
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [BUS_SEL_W-1:0] MEM_SEL = BUS_SEL_W'(MEM_SLOT);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(WAIT_MAX);
  localparam logic [NB-1:0]        ONE_NB  = NB'(1);
  localparam logic [NA-1:0]        ONE_NA  = NA'(1);

  logic                  valid_q, valid_d;
  logic [BUS_SEL_W-1:0]  asel_q, asel_d;
  logic [BUS_SEL_W-1:0]  lsel_q, lsel_d;
  logic [ADDR_SEL_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cont_err_q, cont_err_d;
  logic                  tout_err_q, tout_err_d;

  logic mem_op;
  logic at_max;
  logic stall;
  logic timeout;
  logic strobe;
  logic contend;

  always_comb begin
    mem_op  = valid_q && ((asel_q == MEM_SEL) || (lsel_q == MEM_SEL));
    at_max  = (cnt_q == CNT_MAX);
    stall   = mem_op && !Mem_Ready && !at_max;
    timeout = mem_op && !Mem_Ready && at_max;
    // An op completes in any stage cycle that is neither waiting nor aborting.
    strobe  = valid_q && !stall && !timeout;
    contend = (Bus_Assert == Bus_Load) && (Bus_Assert != '0);
  end

  always_comb begin
    valid_d = valid_q;
    asel_d  = asel_q;
    lsel_d  = lsel_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d = Ctrl_Valid;
      cnt_d   = '0;
      if (Ctrl_Valid) begin
        // A contended word keeps its address source but drives nothing onto the bus.
        asel_d = contend ? '0 : Bus_Assert;
        lsel_d = contend ? '0 : Bus_Load;
        addr_d = AddrSel;
      end
    end
  end

  always_comb begin
    cont_err_d = (Ctrl_Valid && !stall && contend) || (cont_err_q && !Clear_Err);
    tout_err_d = timeout || (tout_err_q && !Clear_Err);
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      valid_q    <= 1'b0;
      asel_q     <= '0;
      lsel_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      cont_err_q <= 1'b0;
      tout_err_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      asel_q     <= asel_d;
      lsel_q     <= lsel_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cont_err_q <= cont_err_d;
      tout_err_q <= tout_err_d;
    end
  end

  always_comb begin
    Assert_N = '1;
    if (valid_q) begin
      Assert_N = ~(ONE_NB << asel_q);
    end
    Assert_N[0] = 1'b1;

    Load_N = '1;
    if (strobe) begin
      Load_N = ~(ONE_NB << lsel_q);
    end
    Load_N[0] = 1'b1;

    AddrSel_N = '1;
    if (valid_q) begin
      AddrSel_N = ~(ONE_NA << addr_q);
    end
  end

  always_comb begin
    Stall               = stall;
    Stage_Valid         = valid_q;
    Mem_Req             = mem_op;
    MemBridge_Direction = !(valid_q && (lsel_q == MEM_SEL));
    Contention_Err      = cont_err_q;
    Timeout_Err         = tout_err_q;
  end

endmodule

// File: tb/tb_bus_control_pipe.sv
// Directed bench for bus_control_pipe: a table of per-cycle vectors plus hand sequences for
// reset during a memory wait and a timeout colliding with Clear_Err.
module tb_bus_control_pipe;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ctrl_valid;
  logic [3:0]  bus_assert;
  logic [3:0]  bus_load;
  logic [2:0]  addr_sel;
  logic        mem_ready;
  logic        clear_err;
  logic        stall;
  logic        stage_valid;
  logic [15:0] assert_n;
  logic [15:0] load_n;
  logic [7:0]  addr_sel_n;
  logic        mem_req;
  logic        dir;
  logic        cont_err;
  logic        tout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_control_pipe #(
    .BUS_SEL_W (4),
    .ADDR_SEL_W(3),
    .MEM_SLOT  (15),
    .WAIT_MAX  (7)
  ) dut (
    .Clock_In           (clk),
    .Reset_In           (rst_b),
    .Ctrl_Valid         (ctrl_valid),
    .Bus_Assert         (bus_assert),
    .Bus_Load           (bus_load),
    .AddrSel            (addr_sel),
    .Mem_Ready          (mem_ready),
    .Clear_Err          (clear_err),
    .Stall              (stall),
    .Stage_Valid        (stage_valid),
    .Assert_N           (assert_n),
    .Load_N             (load_n),
    .AddrSel_N          (addr_sel_n),
    .Mem_Req            (mem_req),
    .MemBridge_Direction(dir),
    .Contention_Err     (cont_err),
    .Timeout_Err        (tout_err)
  );

  // Inputs applied in a cycle, and the outputs expected during that same cycle.
  typedef struct {
    logic        cv;
    logic [3:0]  ba;
    logic [3:0]  bl;
    logic [2:0]  ad;
    logic        rdy;
    logic        clr;
    logic        stall;
    logic        sv;
    logic [15:0] a_n;
    logic [15:0] l_n;
    logic [7:0]  s_n;
    logic        req;
    logic        dir;
    logic        ce;
    logic        te;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cv, input logic [3:0] ba, input logic [3:0] bl,
                     input logic [2:0] ad, input logic rdy, input logic clr,
                     input logic st, input logic sv, input logic [15:0] a_n,
                     input logic [15:0] l_n, input logic [7:0] s_n, input logic req,
                     input logic dr, input logic ce, input logic te);
    vec_t v;
    v.cv = cv; v.ba = ba; v.bl = bl; v.ad = ad; v.rdy = rdy; v.clr = clr;
    v.stall = st; v.sv = sv; v.a_n = a_n; v.l_n = l_n; v.s_n = s_n;
    v.req = req; v.dir = dr; v.ce = ce; v.te = te;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic cv, input logic [3:0] ba, input logic [3:0] bl,
                      input logic [2:0] ad, input logic rdy, input logic clr,
                      input logic ce, input logic te);
    add(cv, ba, bl, ad, rdy, clr, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b0, 1'b1, ce, te);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [3:0] ba, input logic [3:0] bl,
                       input logic [2:0] ad, input logic rdy, input logic clr);
    ctrl_valid = cv; bus_assert = ba; bus_load = bl; addr_sel = ad;
    mem_ready = rdy; clear_err = clr;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("stall", idx, {15'd0, stall}, {15'd0, v.stall});
    chk("stage_valid", idx, {15'd0, stage_valid}, {15'd0, v.sv});
    chk("assert_n", idx, assert_n, v.a_n);
    chk("load_n", idx, load_n, v.l_n);
    chk("addrsel_n", idx, {8'd0, addr_sel_n}, {8'd0, v.s_n});
    chk("mem_req", idx, {15'd0, mem_req}, {15'd0, v.req});
    chk("direction", idx, {15'd0, dir}, {15'd0, v.dir});
    chk("contention_err", idx, {15'd0, cont_err}, {15'd0, v.ce});
    chk("timeout_err", idx, {15'd0, tout_err}, {15'd0, v.te});
  endtask

  initial begin
    vec_t v;

    // register op, then four back-to-back ops
    add(1, 1, 3, 2, 0, 0,  0, 0, 16'hFFFF, 16'hFFFF, 8'hFF, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFFD, 16'hFFF7, 8'hFB, 0, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 2, 4, 0, 0, 0, 0, 0);
    add(1, 3, 5, 1, 0, 0,  0, 1, 16'hFFFB, 16'hFFEF, 8'hFE, 0, 1, 0, 0);
    add(1, 4, 6, 3, 0, 0,  0, 1, 16'hFFF7, 16'hFFDF, 8'hFD, 0, 1, 0, 0);
    add(1, 6, 7, 7, 0, 0,  0, 1, 16'hFFEF, 16'hFFBF, 8'hF7, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFBF, 16'hFF7F, 8'h7F, 0, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    // memory load, ready after three wait cycles; upstream holds the next word
    idle(1, 0, 15, 4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 1, 2, 0, 0, 0,  1, 1, 16'hFFFF, 16'hFFFF, 8'hEF, 1, 0, 0, 0);
    add(1, 1, 2, 0, 1, 0,  0, 1, 16'hFFFF, 16'h7FFF, 8'hEF, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFFD, 16'hFFFB, 8'hFE, 0, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    // zero-wait memory assert
    idle(1, 15, 0, 5, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 1, 16'h7FFF, 16'hFFFF, 8'hDF, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    // timeout: seven stall cycles, abort in the eighth
    idle(1, 15, 0, 6, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 0, 0, 0,  1, 1, 16'h7FFF, 16'hFFFF, 8'hBF, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'h7FFF, 16'hFFFF, 8'hBF, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1, 0, 1);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    // contention, clear, then contention colliding with clear
    idle(1, 5, 5, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFFF, 16'hFFFF, 8'hF7, 0, 1, 1, 0);
    idle(0, 0, 0, 0, 0, 1, 1, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 5, 5, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFFF, 16'hFFFF, 8'hFE, 0, 1, 1, 0);
    idle(1, 0, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 16'hFFFF, 16'hFFFF, 8'hFB, 0, 1, 0, 0);
    idle(0, 0, 0, 0, 0, 0, 0, 0);

    // reset with random inputs
    rst_b = 1'b0;
    drive(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    #1;
    v.stall = 0; v.sv = 0; v.a_n = 16'hFFFF; v.l_n = 16'hFFFF; v.s_n = 8'hFF;
    v.req = 0; v.dir = 1; v.ce = 0; v.te = 0;
    chk_all(-1, v);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_b = 1'b1;
      drive(tbl[i].cv, tbl[i].ba, tbl[i].bl, tbl[i].ad, tbl[i].rdy, tbl[i].clr);
      #1;
      chk_all(i, tbl[i]);
    end

    // reset on the second stall cycle of a memory load
    @(negedge clk);
    drive(1, 0, 15, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_wait stall1", 100, {15'd0, stall}, 16'd1);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("rst_wait stall2", 101, {15'd0, stall}, 16'd1);
    chk("rst_wait load_n", 101, load_n, 16'hFFFF);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rst_wait valid", 102, {15'd0, stage_valid}, 16'd0);
    chk("rst_wait stall", 102, {15'd0, stall}, 16'd0);
    chk("rst_wait mem_req", 102, {15'd0, mem_req}, 16'd0);
    chk("rst_wait load_n", 102, load_n, 16'hFFFF);

    // fresh memory op after reset must wait the full seven cycles (counter restarted)
    @(negedge clk);
    drive(1, 15, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rst stall", 110 + i, {15'd0, stall}, 16'd1);
    end
    // timeout cycle with Clear_Err: the set must win
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("to_clr stall", 120, {15'd0, stall}, 16'd0);
    chk("to_clr load_n", 120, load_n, 16'hFFFF);
    chk("to_clr mem_req", 120, {15'd0, mem_req}, 16'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("to_clr flag", 121, {15'd0, tout_err}, 16'd1);
    chk("to_clr valid", 121, {15'd0, stage_valid}, 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("to_clr cleared", 122, {15'd0, tout_err}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
